// File: rtl/seg_count_monitor.sv
// seg_count_monitor: decodes and glitch-filters a two-digit seven-segment link and checks its 00..99 count.
// Define SEG_ACTIVE_LOW_EN to invert both segment inputs for common-anode displays.
module seg_count_monitor #(
   parameter int STABLE_CYC = 2,
   parameter int ERR_W      = 8
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic [6:0]       seg_one,
   input  logic [6:0]       seg_ten,
   input  logic             clr_err,
   output logic [3:0]       digit_one,
   output logic [3:0]       digit_ten,
   output logic             value_valid,
   output logic             locked,
   output logic             step_pulse,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_cnt
);
   typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;
   state_t           r_state, w_state_nx;
   logic [13:0]      w_raw, r_sample, r_acc;
   logic [3:0]       r_stab;
   logic             r_have;
   logic [4:0]       w_dec_one, w_dec_ten;
   logic             w_valid_pair, w_accept;
   logic [6:0]       w_cur, w_new, w_exp;
   logic [3:0]       r_one, r_ten, w_one_nx, w_ten_nx;
   logic             r_valid, w_valid_nx, r_step, w_step_nx, r_err, w_err_nx;
   logic [ERR_W-1:0] r_cnt;

   // returns {legal, digit}
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      case (s)
         7'h3F:   seg_dec = 5'h10;
         7'h06:   seg_dec = 5'h11;
         7'h5B:   seg_dec = 5'h12;
         7'h4F:   seg_dec = 5'h13;
         7'h66:   seg_dec = 5'h14;
         7'h6D:   seg_dec = 5'h15;
         7'h7D:   seg_dec = 5'h16;
         7'h07:   seg_dec = 5'h17;
         7'h7F:   seg_dec = 5'h18;
         7'h6F:   seg_dec = 5'h19;
         default: seg_dec = 5'h00;
      endcase
   endfunction

`ifdef SEG_ACTIVE_LOW_EN
   assign w_raw = ~{seg_ten, seg_one};
`else
   assign w_raw = {seg_ten, seg_one};
`endif

   assign w_dec_one    = seg_dec(r_sample[6:0]);
   assign w_dec_ten    = seg_dec(r_sample[13:7]);
   assign w_valid_pair = w_dec_one[4] & w_dec_ten[4];
   assign w_accept     = (r_stab >= 4'(STABLE_CYC)) && (!r_have || r_sample != r_acc);
   assign w_cur        = {3'd0, r_ten} * 7'd10 + {3'd0, r_one};
   assign w_new        = {3'd0, w_dec_ten[3:0]} * 7'd10 + {3'd0, w_dec_one[3:0]};
   assign w_exp        = (w_cur == 7'd99) ? 7'd0 : w_cur + 7'd1;

   always_comb begin
      w_state_nx = r_state;
      w_one_nx   = r_one;
      w_ten_nx   = r_ten;
      w_valid_nx = r_valid;
      w_step_nx  = 1'b0;
      w_err_nx   = 1'b0;
      if (w_accept && w_valid_pair) begin
         w_one_nx   = w_dec_one[3:0];
         w_ten_nx   = w_dec_ten[3:0];
         w_valid_nx = 1'b1;
         w_state_nx = S_LOCKED;
         w_step_nx  = (r_state == S_LOCKED) && (w_new == w_exp);
         w_err_nx   = (r_state == S_LOCKED) && (w_new != w_exp);
      end else if (w_accept) begin
         w_valid_nx = 1'b0;
         w_state_nx = S_UNLOCKED;
         w_err_nx   = (r_state == S_LOCKED);
      end
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_state  <= S_UNLOCKED;
         r_sample <= '0;
         r_stab   <= '0;
         r_acc    <= '0;
         r_have   <= 1'b0;
         r_one    <= '0;
         r_ten    <= '0;
         r_valid  <= 1'b0;
         r_step   <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_sample <= w_raw;
         r_stab   <= (w_raw != r_sample) ? 4'd1 : (r_stab == 4'hF) ? r_stab : r_stab + 4'd1;
         r_one    <= w_one_nx;
         r_ten    <= w_ten_nx;
         r_valid  <= w_valid_nx;
         r_step   <= w_step_nx;
         r_err    <= w_err_nx;
         // an unlock forgets the accepted pair so the next stable pair is taken fresh
         if (w_accept) begin
            r_acc  <= r_sample;
            r_have <= !(r_state == S_LOCKED && !w_valid_pair);
         end
         if (clr_err)
            r_cnt <= '0;
         else if (w_err_nx && r_cnt != '1)
            r_cnt <= r_cnt + ERR_W'(1);
      end
   end

   assign digit_one   = r_one;
   assign digit_ten   = r_ten;
   assign value_valid = r_valid;
   assign locked      = (r_state == S_LOCKED);
   assign step_pulse  = r_step;
   assign seq_err     = r_err;
   assign err_cnt     = r_cnt;
endmodule

// File: tb/tb_seg_count_monitor.sv
// tb_seg_count_monitor: directed bench with an expected-event scoreboard for seg_count_monitor.
// Honours SEG_ACTIVE_LOW_EN by inverting the driven patterns.
module tb_seg_count_monitor;
   logic       clkin = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] seg_one = '0, seg_ten = '0;
   logic       clr_err = 1'b0;
   logic [3:0] digit_one, digit_ten;
   logic       value_valid, locked, step_pulse, seq_err;
   logic [7:0] err_cnt;
   int         total = 0, bad = 0, n_step = 0;
   logic [10:0] exp_q[$];
   logic [6:0] tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   localparam logic [1:0] K_STEP = 2'b01, K_ERR = 2'b10;

   seg_count_monitor dut (
      .clkin(clkin), .rst(rst), .seg_one(seg_one), .seg_ten(seg_ten), .clr_err(clr_err),
      .digit_one(digit_one), .digit_ten(digit_ten), .value_valid(value_valid), .locked(locked),
      .step_pulse(step_pulse), .seq_err(seq_err), .err_cnt(err_cnt)
   );

   always #5 clkin = ~clkin;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input logic [1:0] k, input int v, input logic vld);
      exp_q.push_back({k, 4'(v / 10), 4'(v % 10), vld});
   endtask

   // one cycle; any pulse seen is matched against the oldest expected event
   task automatic cyc();
      logic [10:0] o, e;
      @(negedge clkin);
      if (step_pulse || seq_err) begin
         o = {seq_err, step_pulse, digit_ten, digit_one, value_valid};
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
         chk("event", 32'(o), 32'(e));
         n_step += int'(step_pulse);
      end
   endtask

   task automatic hold_raw(input logic [6:0] t, input logic [6:0] o, input int n);
`ifdef SEG_ACTIVE_LOW_EN
      seg_ten = ~t;
      seg_one = ~o;
`else
      seg_ten = t;
      seg_one = o;
`endif
      repeat (n) cyc();
   endtask

   task automatic hold_val(input int v, input int n);
      hold_raw(tab[v / 10], tab[v % 10], n);
   endtask

   initial begin
      repeat (4) begin
         seg_one = 7'($urandom);
         seg_ten = 7'($urandom);
         @(negedge clkin);
         chk("reset_outs", 32'({digit_one, digit_ten, value_valid, locked, step_pulse, seq_err, err_cnt}), 0);
      end
      rst = 1'b1;
      hold_val(0, 3);
      chk("lock_locked", 32'(locked), 1);
      chk("lock_valid", 32'(value_valid), 1);
      chk("lock_digits", 32'({digit_ten, digit_one}), 32'h00);
      chk("lock_nostep", 32'(n_step), 0);

      expect_ev(K_STEP, 1, 1'b1);
      hold_val(1, 3);
      chk("step1_digit", 32'(digit_one), 1);
      chk("step1_count", 32'(n_step), 1);
      for (int v = 2; v <= 99; v++) begin
         expect_ev(K_STEP, v, 1'b1);
         hold_val(v, 3);
      end
      chk("run_steps", 32'(n_step), 99);
      chk("run_errcnt", 32'(err_cnt), 0);
      chk("run_pending", 32'(exp_q.size()), 0);

      expect_ev(K_STEP, 0, 1'b1);
      hold_val(0, 3);
      chk("wrap_digits", 32'({digit_ten, digit_one}), 32'h00);
      chk("wrap_steps", 32'(n_step), 100);
      chk("wrap_errcnt", 32'(err_cnt), 0);

      for (int v = 1; v <= 19; v++) begin
         expect_ev(K_STEP, v, 1'b1);
         hold_val(v, 3);
      end
      expect_ev(K_STEP, 20, 1'b1);
      hold_val(29, 1);
      hold_val(20, 3);
      chk("glitch_steps", 32'(n_step), 120);
      chk("glitch_digits", 32'({digit_ten, digit_one}), 32'h20);
      chk("glitch_pending", 32'(exp_q.size()), 0);

      #2 rst = 1'b0;
      #1 chk("midrst_outs", 32'({digit_one, digit_ten, value_valid, locked, step_pulse, seq_err, err_cnt}), 0);
      @(negedge clkin);
      rst = 1'b1;
      hold_val(5, 3);
      chk("relock_locked", 32'(locked), 1);
      chk("relock_digits", 32'({digit_ten, digit_one}), 32'h05);
      chk("relock_errcnt", 32'(err_cnt), 0);

      expect_ev(K_ERR, 7, 1'b1);
      hold_val(7, 3);
      chk("skip_errcnt", 32'(err_cnt), 1);
      chk("skip_digits", 32'({digit_ten, digit_one}), 32'h07);
      expect_ev(K_STEP, 8, 1'b1);
      hold_val(8, 3);
      chk("skip_pending", 32'(exp_q.size()), 0);

      expect_ev(K_ERR, 8, 1'b0);
      hold_raw(tab[0], 7'h00, 6);
      chk("inv_locked", 32'(locked), 0);
      chk("inv_valid", 32'(value_valid), 0);
      chk("inv_errcnt", 32'(err_cnt), 2);
      chk("inv_digits", 32'({digit_ten, digit_one}), 32'h08);

      hold_val(10, 3);
      chk("inv_relock", 32'({locked, value_valid, digit_ten, digit_one}), 32'h310);
      for (int i = 0; i < 300; i++) begin
         expect_ev(K_ERR, (i % 2) ? 10 : 50, 1'b1);
         hold_val((i % 2) ? 10 : 50, 3);
      end
      chk("sat_errcnt", 32'(err_cnt), 255);
      chk("sat_pending", 32'(exp_q.size()), 0);

      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("clr_errcnt", 32'(err_cnt), 0);

      expect_ev(K_ERR, 50, 1'b1);
      hold_val(50, 2);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("clr_wins", 32'(err_cnt), 0);
      expect_ev(K_ERR, 10, 1'b1);
      hold_val(10, 3);
      chk("after_clr", 32'(err_cnt), 1);
      repeat (3) cyc();
      chk("final_pending", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
